sy_ppl_bp_predec: RTL and testbench
===================================

Name: sy_ppl_bp_predec

Overview:
- Fetch-side pre-decode stage, directly upstream of the return address stack and decode.
- Accepts one fetched instruction per cycle and classifies it as call, return, direct jump or other.
- Drives the RAS push/pop/data signals and predicts the next PC for JAL and for returns.
- Issues a one-cycle redirect to PC generation and discards wrong-path fetches until the predicted target arrives.

Parameters:
- AWTH, from sy_pkg: address width used for PCs and return addresses.
- LINK_X5, default 1: 1 treats x5 as well as x1 as a link register; 0 treats x1 only.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset, asynchronous, active-low
- flush_i  in  1  pipeline flush from backend
- fetch_vld_i  in  1  fetch instruction valid
- fetch_rdy_o  out  1  stage ready
- fetch_pc_i  in  AWTH  instruction PC
- fetch_instr_i  in  32  instruction word
- ras_i  in  ras_t  current RAS top entry (fields vld, ra)
- ras_push_o  out  1  RAS push
- ras_pop_o  out  1  RAS pop
- ras_data_o  out  AWTH  return address to push
- dec_vld_o  out  1  output valid to decode
- dec_rdy_i  in  1  decode ready
- dec_pc_o  out  AWTH  registered PC
- dec_instr_o  out  32  registered instruction
- dec_pred_taken_o  out  1  prediction made
- dec_pred_npc_o  out  AWTH  predicted next PC (pc+len when not taken)
- redir_vld_o  out  1  redirect pulse to PC gen
- redir_pc_o  out  AWTH  redirect target

Behaviour:
- Reset values:
  - all outputs 0.
  - FSM in RUN, stage register empty.
- Handshake:
  - Accept = fetch_vld_i && fetch_rdy_o.
  - In RUN, fetch_rdy_o = !dec_vld_o || dec_rdy_i.
  - In DROP, fetch_rdy_o = 1.
  - dec_* outputs hold stable while dec_vld_o && !dec_rdy_i.
- Latency: accepted instruction appears on dec_* the next cycle.
- Classification (link = x1, plus x5 when LINK_X5=1):
  - JAL with rd=link: call. Push pc+4; taken; target pc+sext(imm21).
  - JAL with any other rd: direct jump. Taken, no RAS action.
  - JALR, rd=link, rs1 not link: call. Push pc+4; not taken.
  - JALR, rd=x0, rs1=link, imm=0: return. Pop; taken to ras_i.ra only if ras_i.vld.
  - JALR, rd=link, rs1=link, rd!=rs1: push and pop in the same cycle (coroutine); taken to ras_i.ra if ras_i.vld.
  - JALR, rd=link, rs1=link, rd==rs1: push only.
  - Return while ras_i.vld=0: no pop, not taken.
  - All other instructions: no action; pred_npc = pc+4.
- RAS timing:
  - ras_push_o/ras_pop_o are combinational and asserted only in a cycle where accept is true, FSM is RUN (or the DROP match cycle), and flush_i=0.
  - RAS and the stage register therefore update on the same edge.
- Address arithmetic: modulo 2^AWTH, wraps with no error.
- Redirect:
  - When an accepted instruction is predicted taken, the next cycle has redir_vld_o=1 and redir_pc_o=target, for exactly one cycle.
  - FSM moves RUN->DROP.
- DROP state:
  - Accepted fetches whose fetch_pc_i != target are discarded: no RAS action, no dec output.
  - The first fetch with fetch_pc_i == target is processed as in RUN, and FSM moves DROP->RUN in the same edge.
  - If that instruction is itself taken, a new redirect is issued and FSM re-enters DROP with the new target.
- Flush (highest priority):
  - clears dec_vld_o, FSM to RUN, redir_vld_o to 0 next cycle.
  - suppresses push/pop in the flush cycle.
  - any instruction presented in the flush cycle is dropped.
- Reset mid-operation: immediate return to reset state, including while a redirect is pending.

Optional Feature:
- Macro: SY_PPL_PREDEC_RVC_EN.
- Defined:
  - fetch_instr_i[1:0]!=2'b11 decodes as RVC with length 2.
  - c.jal and c.jalr are calls, pushing pc+2.
  - c.jr x1 (or x5) is a return.
  - c.j is a direct jump.
  - pred_npc defaults to pc+2.
- Undefined: all instructions are length 4; compressed encodings are classified "other".

Test Plan:
- pc=0x1000, JAL x1,+0x100 accepted -> ras_push_o=1, ras_data_o=0x1004; next cycle redir_vld_o=1, redir_pc_o=0x1100, dec_pred_npc_o=0x1100.
- ras_i={vld=1,ra=0x1004}, JALR x0,0(x1) at 0x1100 -> ras_pop_o=1; redirect to 0x1004. Then fetches 0x1104 and 0x1108 are dropped with no RAS action, and 0x1004 passes to dec.
- Return with ras_i.vld=0 -> no pop, dec_pred_taken_o=0, no redirect.
- JALR x1,0(x5) with LINK_X5=1 -> push and pop in the same cycle, ras_data_o=pc+4; JALR x1,0(x1) -> push only.
- dec_rdy_i=0 for 3 cycles with dec_vld_o=1 -> fetch_rdy_o=0, dec outputs stable, no push/pop.
- flush_i asserted together with an accepted JAL x1 -> no push, no redirect, dec_vld_o=0 next cycle, FSM in RUN.

Source files
------------

// File: rtl/sy_ppl_bp_predec.sv
// Fetch-side pre-decode: call/return/jump classify, RAS control, redirect.
// Optional RVC support: define SY_PPL_PREDEC_RVC_EN.
package sy_pkg;
  localparam int AWTH = 32;
  typedef struct packed {
    logic            vld;
    logic [AWTH-1:0] ra;
  } ras_t;
endpackage

module sy_ppl_bp_predec
  import sy_pkg::*;
#(
  parameter bit LINK_X5 = 1'b1
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            flush_i,
  input  logic            fetch_vld_i,
  output logic            fetch_rdy_o,
  input  logic [AWTH-1:0] fetch_pc_i,
  input  logic [31:0]     fetch_instr_i,
  input  ras_t            ras_i,
  output logic            ras_push_o,
  output logic            ras_pop_o,
  output logic [AWTH-1:0] ras_data_o,
  output logic            dec_vld_o,
  input  logic            dec_rdy_i,
  output logic [AWTH-1:0] dec_pc_o,
  output logic [31:0]     dec_instr_o,
  output logic            dec_pred_taken_o,
  output logic [AWTH-1:0] dec_pred_npc_o,
  output logic            redir_vld_o,
  output logic [AWTH-1:0] redir_pc_o
);

  localparam logic RUN  = 1'b0;
  localparam logic DROP = 1'b1;

  logic            st;
  logic [AWTH-1:0] tgt_q;

  logic [31:0]     i;
  logic [4:0]      rd;
  logic [4:0]      rs1;
  logic            is_jal;
  logic            is_jalr;
  logic [AWTH-1:0] imm_j;
`ifdef SY_PPL_PREDEC_RVC_EN
  logic [AWTH-1:0] imm_cj;
  logic [4:0]      rs1_c;
`endif

  logic            push;
  logic            pop;
  logic            taken;
  logic [AWTH-1:0] plen;
  logic [AWTH-1:0] tgt;
  logic [AWTH-1:0] seq;
  logic [AWTH-1:0] npc;

  logic            match;
  logic            room;
  logic            accept;
  logic            proc;

  function automatic logic is_link(input logic [4:0] r);
    return (r == 5'd1) || (LINK_X5 && (r == 5'd5));
  endfunction

  assign i       = fetch_instr_i;
  assign rd      = i[11:7];
  assign rs1     = i[19:15];
  assign is_jal  = (i[6:0] == 7'h6f);
  assign is_jalr = (i[6:0] == 7'h67) && (i[14:12] == 3'b000);
  assign imm_j   = {{(AWTH-20){i[31]}}, i[19:12],
                    i[20], i[30:21], 1'b0};
`ifdef SY_PPL_PREDEC_RVC_EN
  assign imm_cj  = {{(AWTH-11){i[12]}}, i[8], i[10:9],
                    i[6], i[7], i[2], i[11], i[5:3], 1'b0};
  assign rs1_c   = i[11:7];
`endif

  // Classify the fetched word and form RAS action and predicted target.
  always_comb begin
    push  = 1'b0;
    pop   = 1'b0;
    taken = 1'b0;
    plen  = AWTH'(4);
    tgt   = fetch_pc_i + imm_j;
`ifdef SY_PPL_PREDEC_RVC_EN
    if (i[1:0] != 2'b11) begin
      plen = AWTH'(2);
      tgt  = fetch_pc_i + imm_cj;
      unique case (1'b1)
        (i[1:0] == 2'b01 && i[15:13] == 3'b001): begin
          push  = 1'b1;
          taken = 1'b1;
        end
        (i[1:0] == 2'b01 && i[15:13] == 3'b101): begin
          taken = 1'b1;
        end
        (i[1:0] == 2'b10 && i[15:12] == 4'b1001
         && rs1_c != 5'd0 && i[6:2] == 5'd0): begin
          push = 1'b1;
          if (is_link(rs1_c) && rs1_c != 5'd1 && ras_i.vld) begin
            pop   = 1'b1;
            taken = 1'b1;
            tgt   = ras_i.ra;
          end
        end
        (i[1:0] == 2'b10 && i[15:12] == 4'b1000
         && i[6:2] == 5'd0 && is_link(rs1_c) && ras_i.vld): begin
          pop   = 1'b1;
          taken = 1'b1;
          tgt   = ras_i.ra;
        end
        default: ;
      endcase
    end else
`endif
    begin
      if (is_jal) begin
        taken = 1'b1;
        push  = is_link(rd);
      end else if (is_jalr) begin
        if (is_link(rd) && is_link(rs1)) begin
          push = 1'b1;
          if (rd != rs1 && ras_i.vld) begin
            pop   = 1'b1;
            taken = 1'b1;
            tgt   = ras_i.ra;
          end
        end else if (is_link(rd)) begin
          push = 1'b1;
        end else if (rd == 5'd0 && is_link(rs1)
                     && i[31:20] == 12'd0 && ras_i.vld) begin
          pop   = 1'b1;
          taken = 1'b1;
          tgt   = ras_i.ra;
        end
      end
    end
  end

  assign seq = fetch_pc_i + plen;
  assign npc = taken ? tgt : seq;

  // A DROP-state target match must not overwrite a stalled stage register.
  assign match       = (fetch_pc_i == tgt_q);
  assign room        = !dec_vld_o || dec_rdy_i;
  assign fetch_rdy_o = (st == DROP && !match) ? 1'b1 : room;
  assign accept      = fetch_vld_i && fetch_rdy_o;
  assign proc        = accept && !flush_i
                       && (st == RUN || match);

  assign ras_push_o = proc && push;
  assign ras_pop_o  = proc && pop;
  assign ras_data_o = ras_push_o ? seq : '0;

  // Stage register, redirect pulse and RUN/DROP tracking.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      st               <= RUN;
      tgt_q            <= '0;
      dec_vld_o        <= 1'b0;
      dec_pc_o         <= '0;
      dec_instr_o      <= '0;
      dec_pred_taken_o <= 1'b0;
      dec_pred_npc_o   <= '0;
      redir_vld_o      <= 1'b0;
      redir_pc_o       <= '0;
    end else if (flush_i) begin
      st          <= RUN;
      dec_vld_o   <= 1'b0;
      redir_vld_o <= 1'b0;
    end else begin
      redir_vld_o <= proc && taken;
      if (proc && taken) begin
        redir_pc_o <= npc;
        tgt_q      <= npc;
      end
      if (proc) begin
        st               <= taken ? DROP : RUN;
        dec_vld_o        <= 1'b1;
        dec_pc_o         <= fetch_pc_i;
        dec_instr_o      <= fetch_instr_i;
        dec_pred_taken_o <= taken;
        dec_pred_npc_o   <= npc;
      end else if (dec_rdy_i) begin
        dec_vld_o <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_sy_ppl_bp_predec.sv
// Testbench for sy_ppl_bp_predec (default build, LINK_X5=1).
// Scoreboard of expected decode-side transfers.
module tb_sy_ppl_bp_predec;
  import sy_pkg::*;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        taken;
    logic [31:0] npc;
  } exp_t;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        fetch_vld;
  logic        fetch_rdy;
  logic [31:0] fetch_pc;
  logic [31:0] fetch_instr;
  ras_t        ras_in;
  logic        ras_push;
  logic        ras_pop;
  logic [31:0] ras_data;
  logic        dec_vld;
  logic        dec_rdy;
  logic [31:0] dec_pc;
  logic [31:0] dec_instr;
  logic        dec_taken;
  logic [31:0] dec_npc;
  logic        redir_vld;
  logic [31:0] redir_pc;

  int   total = 0;
  int   bad   = 0;
  exp_t q[$];

  always #5 clk = ~clk;

  sy_ppl_bp_predec dut (
    .clk_i(clk), .rst_i(rst_n), .flush_i(flush),
    .fetch_vld_i(fetch_vld), .fetch_rdy_o(fetch_rdy),
    .fetch_pc_i(fetch_pc), .fetch_instr_i(fetch_instr),
    .ras_i(ras_in), .ras_push_o(ras_push),
    .ras_pop_o(ras_pop), .ras_data_o(ras_data),
    .dec_vld_o(dec_vld), .dec_rdy_i(dec_rdy),
    .dec_pc_o(dec_pc), .dec_instr_o(dec_instr),
    .dec_pred_taken_o(dec_taken),
    .dec_pred_npc_o(dec_npc),
    .redir_vld_o(redir_vld), .redir_pc_o(redir_pc)
  );

  function automatic logic [31:0] enc_jal(
    input logic [4:0] rd, input logic [20:0] imm);
    return {imm[20], imm[10:1], imm[11], imm[19:12],
            rd, 7'h6f};
  endfunction

  function automatic logic [31:0] enc_jalr(
    input logic [4:0] rd, input logic [4:0] rs1,
    input logic [11:0] imm);
    return {imm, rs1, 3'b000, rd, 7'h67};
  endfunction

  // Pops the scoreboard on every decode-side transfer.
  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && dec_vld && dec_rdy && !flush) begin
        total++;
        if (q.size() == 0) begin
          bad++;
          $display("FAIL dec_unexpected pc=%h", dec_pc);
        end else begin
          e = q.pop_front();
          if (dec_pc !== e.pc || dec_instr !== e.instr
              || dec_taken !== e.taken
              || dec_npc !== e.npc) begin
            bad++;
            $display("FAIL dec_out got pc=%h ins=%h t=%b npc=%h want pc=%h ins=%h t=%b npc=%h",
                     dec_pc, dec_instr, dec_taken, dec_npc,
                     e.pc, e.instr, e.taken, e.npc);
          end
        end
      end
    end
  endtask

  // Called at posedge+1; returns at posedge+1 after acceptance.
  task automatic send(
    input logic [31:0] pc, input logic [31:0] ins,
    input bit epush, input bit epop,
    input bit deliver, input bit etaken,
    input logic [31:0] enpc, input string nm);
    int n;
    fetch_vld   = 1'b1;
    fetch_pc    = pc;
    fetch_instr = ins;
    #1;
    n = 0;
    while (!fetch_rdy && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    total++;
    if (n >= 20) begin
      bad++;
      $display("FAIL %s rdy_timeout got=0 want=1", nm);
    end
    total++;
    if (ras_push !== epush || ras_pop !== epop) begin
      bad++;
      $display("FAIL %s ras got push=%b pop=%b want push=%b pop=%b",
               nm, ras_push, ras_pop, epush, epop);
    end
    if (epush) begin
      total++;
      if (ras_data !== pc + 32'd4) begin
        bad++;
        $display("FAIL %s ras_data got=%h want=%h",
                 nm, ras_data, pc + 32'd4);
      end
    end
    if (deliver)
      q.push_back('{pc: pc, instr: ins,
                    taken: etaken, npc: enpc});
    @(posedge clk); #1;
    total++;
    if (redir_vld !== (deliver && etaken)) begin
      bad++;
      $display("FAIL %s redir_vld got=%b want=%b",
               nm, redir_vld, deliver && etaken);
    end
    if (deliver && etaken) begin
      total++;
      if (redir_pc !== enpc) begin
        bad++;
        $display("FAIL %s redir_pc got=%h want=%h",
                 nm, redir_pc, enpc);
      end
    end
  endtask

  task automatic test_reset();
    rst_n       = 1'b0;
    flush       = 1'b0;
    fetch_vld   = 1'b0;
    fetch_pc    = '0;
    fetch_instr = '0;
    ras_in      = '0;
    dec_rdy     = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if ({dec_vld, dec_taken, redir_vld, ras_push, ras_pop}
        !== 5'b0) begin
      bad++;
      $display("FAIL reset_ctl got=%b want=00000",
               {dec_vld, dec_taken, redir_vld, ras_push, ras_pop});
    end
    total++;
    if ({dec_pc, dec_instr, dec_npc, redir_pc, ras_data}
        !== 160'd0) begin
      bad++;
      $display("FAIL reset_data got pc=%h npc=%h rpc=%h want 0",
               dec_pc, dec_npc, redir_pc);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_call_ret();
    send(32'h1000, enc_jal(5'd1, 21'h100),
         1, 0, 1, 1, 32'h1100, "jal_call");
    ras_in.vld = 1'b1;
    ras_in.ra  = 32'h1004;
    send(32'h1100, enc_jalr(5'd0, 5'd1, 12'd0),
         0, 1, 1, 1, 32'h1004, "ret");
    send(32'h1104, NOP, 0, 0, 0, 0, 32'h0, "drop1");
    send(32'h1108, enc_jal(5'd1, 21'h40),
         0, 0, 0, 0, 32'h0, "drop2");
    send(32'h1004, NOP, 0, 0, 1, 0, 32'h1008, "ret_land");
  endtask

  task automatic test_ret_novld();
    ras_in.vld = 1'b0;
    send(32'h2000, enc_jalr(5'd0, 5'd1, 12'd0),
         0, 0, 1, 0, 32'h2004, "ret_novld");
  endtask

  task automatic test_coroutine();
    ras_in.vld = 1'b1;
    ras_in.ra  = 32'h3000;
    send(32'h2004, enc_jalr(5'd1, 5'd5, 12'd0),
         1, 1, 1, 1, 32'h3000, "corout");
    send(32'h3000, enc_jalr(5'd1, 5'd1, 12'd0),
         1, 0, 1, 0, 32'h3004, "push_only");
  endtask

  task automatic test_jump_chain();
    send(32'h3004, enc_jal(5'd0, 21'h1ffff8),
         0, 0, 1, 1, 32'h2ffc, "jal_x0");
    send(32'h2ffc, enc_jal(5'd5, 21'h10),
         1, 0, 1, 1, 32'h300c, "jal_x5_rechain");
    send(32'h3008, NOP, 0, 0, 0, 0, 32'h0, "drop3");
    send(32'h300c, NOP, 0, 0, 1, 0, 32'h3010, "chain_land");
  endtask

  task automatic test_wrap();
    send(32'h0004, enc_jal(5'd0, 21'h1ffff8),
         0, 0, 1, 1, 32'hffff_fffc, "wrap_back");
    send(32'hffff_fffc, NOP, 0, 0, 1, 0, 32'h0,
         "wrap_seq");
  endtask

  task automatic test_stall();
    send(32'h5000, NOP, 0, 0, 1, 0, 32'h5004, "stall_pre");
    dec_rdy     = 1'b0;
    fetch_vld   = 1'b1;
    fetch_pc    = 32'h5004;
    fetch_instr = enc_jal(5'd1, 21'h100);
    for (int k = 0; k < 3; k++) begin
      #1;
      total++;
      if (fetch_rdy !== 1'b0 || ras_push !== 1'b0
          || ras_pop !== 1'b0) begin
        bad++;
        $display("FAIL stall_ctl got rdy=%b push=%b pop=%b want 0 0 0",
                 fetch_rdy, ras_push, ras_pop);
      end
      total++;
      if (dec_vld !== 1'b1 || dec_pc !== 32'h5000
          || dec_instr !== NOP || dec_npc !== 32'h5004) begin
        bad++;
        $display("FAIL stall_hold got v=%b pc=%h npc=%h want 1 5000 5004",
                 dec_vld, dec_pc, dec_npc);
      end
      @(posedge clk); #1;
    end
    dec_rdy = 1'b1;
    send(32'h5004, enc_jal(5'd1, 21'h100),
         1, 0, 1, 1, 32'h5104, "stall_release");
    send(32'h5104, NOP, 0, 0, 1, 0, 32'h5108, "stall_land");
  endtask

  task automatic test_flush();
    fetch_vld = 1'b0;
    @(posedge clk); #1;
    flush       = 1'b1;
    fetch_vld   = 1'b1;
    fetch_pc    = 32'h6000;
    fetch_instr = enc_jal(5'd1, 21'h100);
    #1;
    total++;
    if (ras_push !== 1'b0 || ras_pop !== 1'b0) begin
      bad++;
      $display("FAIL flush_ras got push=%b pop=%b want 0 0",
               ras_push, ras_pop);
    end
    @(posedge clk); #1;
    flush     = 1'b0;
    fetch_vld = 1'b0;
    total++;
    if (dec_vld !== 1'b0 || redir_vld !== 1'b0) begin
      bad++;
      $display("FAIL flush_out got v=%b redir=%b want 0 0",
               dec_vld, redir_vld);
    end
    send(32'h7000, NOP, 0, 0, 1, 0, 32'h7004, "post_flush");
  endtask

  task automatic test_mid_reset();
    fetch_vld   = 1'b1;
    fetch_pc    = 32'h8000;
    fetch_instr = enc_jal(5'd0, 21'h40);
    @(posedge clk); #1;
    fetch_vld = 1'b0;
    total++;
    if (redir_vld !== 1'b1 || redir_pc !== 32'h8040) begin
      bad++;
      $display("FAIL pre_reset_redir got v=%b pc=%h want 1 8040",
               redir_vld, redir_pc);
    end
    rst_n = 1'b0;
    #1;
    total++;
    if (redir_vld !== 1'b0 || dec_vld !== 1'b0
        || redir_pc !== 32'h0) begin
      bad++;
      $display("FAIL mid_reset got redir=%b v=%b rpc=%h want 0 0 0",
               redir_vld, dec_vld, redir_pc);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    send(32'h9000, NOP, 0, 0, 1, 0, 32'h9004, "post_reset");
  endtask

  initial begin
    fork
      monitor();
    join_none
    test_reset();
    test_call_ret();
    test_ret_novld();
    test_coroutine();
    test_jump_chain();
    test_wrap();
    test_stall();
    test_flush();
    test_mid_reset();
    fetch_vld = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL sb_drain got=%0d want=0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
